// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder step per clock, WIDTH+2 cycles per addition.
// Optional two's-complement Overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             Carry,
  output logic             Overflow
`else
  output logic             Carry
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] psum_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             busy_reg;
  logic             done_reg;
`ifdef SERIAL_ADD_OVF_EN
  logic             cmsb_reg;
  logic             ovf_reg;
`endif

  logic sum_bit;
  logic carry_next;

  assign sum_bit    = a_reg[0] ^ b_reg[0] ^ c_reg;
  assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      psum_reg  <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            a_reg     <= A;
            b_reg     <= B;
            psum_reg  <= '0;
            c_reg     <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_reg    <= a_reg >> 1;
          b_reg    <= b_reg >> 1;
          psum_reg <= {sum_bit, psum_reg[WIDTH-1:1]};
          c_reg    <= carry_next;
`ifdef SERIAL_ADD_OVF_EN
          // On the final step c_reg is the carry into the MSB.
          cmsb_reg <= c_reg;
`endif
          cnt_reg  <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= FIN;
          end
        end
        FIN: begin
          sum_reg   <= psum_reg;
          carry_reg <= c_reg;
`ifdef SERIAL_ADD_OVF_EN
          ovf_reg   <= cmsb_reg ^ c_reg;
`endif
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign Busy  = busy_reg;
  assign Done  = done_reg;
  assign Sum   = sum_reg;
  assign Carry = carry_reg;
`ifdef SERIAL_ADD_OVF_EN
  assign Overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); define SERIAL_ADD_OVF_EN to cover Overflow.
module tb_serial_add_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Busy;
  logic       Done;
  logic [7:0] Sum;
  logic       Carry;
`ifdef SERIAL_ADD_OVF_EN
  logic       Overflow;
`endif

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
`ifdef SERIAL_ADD_OVF_EN
    .Carry (Carry),
    .Overflow (Overflow)
`else
    .Carry (Carry)
`endif
  );

  // Launch one addition and observe it for 20 cycles; the bound also covers a missing Done.
  // lat = cycles from the accept-cycle to Done, mid_sum = Sum sampled mid-RUN.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cnt, output int done_cnt,
                        output logic [7:0] mid_sum);
    @(negedge Clk);
    Start = 1'b1; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; A = 8'hAA; B = 8'h55;
    lat = -1; busy_cnt = 0; done_cnt = 0; mid_sum = 8'hxx;
    for (int k = 0; k < 20; k++) begin
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
      if (k == 4) mid_sum = Sum;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; A = 8'd9; B = 8'd9;
    repeat (2) @(negedge Clk);
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", Busy); end
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", Done); end
    tests++; if (Sum !== 8'd0) begin fails++; $display("FAIL reset_sum got %0d exp 0", Sum); end
    tests++; if (Carry !== 1'b0) begin fails++; $display("FAIL reset_carry got %b exp 0", Carry); end
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clk);
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_start_ignored busy got %b exp 0", Busy); end
    $display("[TB] reset: busy=%b done=%b sum=%0d carry=%b", Busy, Done, Sum, Carry);
  endtask

  task automatic test_basic();
    int lat, bc, dc;
    logic [7:0] ms;
    run_op(8'd3, 8'd5, lat, bc, dc, ms);
    tests++; if (lat !== 9) begin fails++; $display("FAIL basic_latency got %0d exp 9", lat); end
    tests++; if (bc !== 9) begin fails++; $display("FAIL basic_busy_cycles got %0d exp 9", bc); end
    tests++; if (dc !== 1) begin fails++; $display("FAIL basic_done_count got %0d exp 1", dc); end
    tests++; if (Sum !== 8'd8) begin fails++; $display("FAIL basic_sum got %0d exp 8", Sum); end
    tests++; if (Carry !== 1'b0) begin fails++; $display("FAIL basic_carry got %b exp 0", Carry); end
`ifdef SERIAL_ADD_OVF_EN
    tests++; if (Overflow !== 1'b0) begin fails++; $display("FAIL basic_ovf got %b exp 0", Overflow); end
`endif
    $display("[TB] 3+5: lat=%0d busy=%0d dones=%0d sum=%0d carry=%b", lat, bc, dc, Sum, Carry);
  endtask

  task automatic test_edges();
    int lat, bc, dc;
    logic [7:0] ms;
    run_op(8'd255, 8'd1, lat, bc, dc, ms);
    tests++; if (ms !== 8'd8) begin fails++; $display("FAIL hold_during_run got %0d exp 8", ms); end
    tests++; if (dc !== 1) begin fails++; $display("FAIL wrap_done_count got %0d exp 1", dc); end
    tests++; if (Sum !== 8'd0) begin fails++; $display("FAIL wrap_sum got %0d exp 0", Sum); end
    tests++; if (Carry !== 1'b1) begin fails++; $display("FAIL wrap_carry got %b exp 1", Carry); end
    $display("[TB] 255+1: sum=%0d carry=%b dones=%0d", Sum, Carry, dc);
    run_op(8'd0, 8'd0, lat, bc, dc, ms);
    tests++; if (dc !== 1) begin fails++; $display("FAIL zero_done_count got %0d exp 1", dc); end
    tests++; if (lat !== 9) begin fails++; $display("FAIL zero_latency got %0d exp 9", lat); end
    tests++; if (Sum !== 8'd0) begin fails++; $display("FAIL zero_sum got %0d exp 0", Sum); end
    tests++; if (Carry !== 1'b0) begin fails++; $display("FAIL zero_carry got %b exp 0", Carry); end
    $display("[TB] 0+0: sum=%0d carry=%b dones=%0d", Sum, Carry, dc);
  endtask

  task automatic test_start_ignored();
    int dc = 0;
    @(negedge Clk);
    Start = 1'b1; A = 8'd10; B = 8'd20;
    @(negedge Clk);
    Start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (k == 3) begin Start = 1'b1; A = 8'd1; B = 8'd1; end
      if (k == 4) Start = 1'b0;
      if (Done) dc++;
      @(negedge Clk);
    end
    tests++; if (dc !== 1) begin fails++; $display("FAIL ignore_done_count got %0d exp 1", dc); end
    tests++; if (Sum !== 8'd30) begin fails++; $display("FAIL ignore_sum got %0d exp 30", Sum); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL ignore_idle_after got %b exp 0", Busy); end
    $display("[TB] 10+20 with mid-run start: sum=%0d dones=%0d", Sum, dc);
  endtask

  task automatic test_reset_abort();
    int dc = 0;
    int lat, bc, dc2;
    logic [7:0] ms;
    @(negedge Clk);
    Start = 1'b1; A = 8'd100; B = 8'd100;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", Busy); end
    tests++; if (Sum !== 8'd0) begin fails++; $display("FAIL abort_sum got %0d exp 0", Sum); end
    tests++; if (Carry !== 1'b0) begin fails++; $display("FAIL abort_carry got %b exp 0", Carry); end
    for (int k = 0; k < 15; k++) begin
      if (Done) dc++;
      @(negedge Clk);
    end
    tests++; if (dc !== 0) begin fails++; $display("FAIL abort_no_done got %0d exp 0", dc); end
    run_op(8'd7, 8'd9, lat, bc, dc2, ms);
    tests++; if (Sum !== 8'd16) begin fails++; $display("FAIL abort_next_sum got %0d exp 16", Sum); end
    tests++; if (dc2 !== 1) begin fails++; $display("FAIL abort_next_done got %0d exp 1", dc2); end
    $display("[TB] abort 100+100 then 7+9: sum=%0d dones_after_abort=%0d", Sum, dc);
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    logic [7:0] s1 = 8'hxx;
    logic [7:0] s2 = 8'hxx;
    logic c1 = 1'bx;
    logic c2 = 1'bx;
    @(negedge Clk);
    Start = 1'b1; A = 8'd1; B = 8'd2;
    @(negedge Clk);
    A = 8'd200; B = 8'd100;
    for (int k = 0; k < 30; k++) begin
      if (Done) begin
        if (d1 < 0) begin d1 = k; s1 = Sum; c1 = Carry; end
        else if (d2 < 0) begin d2 = k; s2 = Sum; c2 = Carry; Start = 1'b0; end
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    tests++; if (d1 !== 9) begin fails++; $display("FAIL b2b_first_done got %0d exp 9", d1); end
    tests++; if (d2 - d1 !== 10) begin fails++; $display("FAIL b2b_spacing got %0d exp 10", d2 - d1); end
    tests++; if (s1 !== 8'd3) begin fails++; $display("FAIL b2b_sum1 got %0d exp 3", s1); end
    tests++; if (c1 !== 1'b0) begin fails++; $display("FAIL b2b_carry1 got %b exp 0", c1); end
    tests++; if (s2 !== 8'd44) begin fails++; $display("FAIL b2b_sum2 got %0d exp 44", s2); end
    tests++; if (c2 !== 1'b1) begin fails++; $display("FAIL b2b_carry2 got %b exp 1", c2); end
    $display("[TB] back-to-back: done@%0d sum=%0d c=%b, done@%0d sum=%0d c=%b", d1, s1, c1, d2, s2, c2);
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_overflow();
    int lat, bc, dc;
    logic [7:0] ms;
    run_op(8'd127, 8'd1, lat, bc, dc, ms);
    tests++; if (Sum !== 8'd128) begin fails++; $display("FAIL ovf_sum got %0d exp 128", Sum); end
    tests++; if (Overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b exp 1", Overflow); end
    $display("[TB] 127+1: sum=%0d ovf=%b", Sum, Overflow);
    run_op(8'd255, 8'd1, lat, bc, dc, ms);
    tests++; if (Overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b exp 0", Overflow); end
    tests++; if (Carry !== 1'b1) begin fails++; $display("FAIL ovf_carry got %b exp 1", Carry); end
    $display("[TB] 255+1: carry=%b ovf=%b", Carry, Overflow);
  endtask
`endif

  initial begin
    Reset = 1'b1; Start = 1'b0; A = 8'd0; B = 8'd0;
    test_reset();
    test_basic();
    test_edges();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
`ifdef SERIAL_ADD_OVF_EN
    test_overflow();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
